// File: rtl/hazard_stall_unit.sv
// Hazard detection and stall control for the five-stage pipeline.
// Covers hazards that forwarding cannot resolve: load-use, producers feeding
// a register branch resolved in ID, and flag producers feeding a conditional
// branch. A two-state FSM stretches the load->register-branch case to two
// stall cycles. A saturating counter tallies stall cycles.
//
//   state | meaning
//   RUN   | normal issue; stalls are raised combinationally from hazard terms
//   HOLD  | second cycle of a load->register-branch stall; inputs ignored
module hazard_stall_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_Regwrite,
  input  logic [3:0]  ID_EX_RegisterRd,
  input  logic        ID_EX_SetsFlags,
  input  logic        EX_MEM_MemRead,
  input  logic [3:0]  EX_MEM_RegisterRd,
  input  logic [3:0]  IF_ID_RegisterRs,
  input  logic [3:0]  IF_ID_RegisterRt,
  input  logic        IF_ID_ReadRs,
  input  logic        IF_ID_ReadRt,
  input  logic        IF_ID_MemWrite,
  input  logic        IF_ID_BranchReg,
  input  logic        IF_ID_Branch,
  input  logic        BranchTaken,
  output logic        PC_write,
  output logic        IF_ID_write,
  output logic        ID_EX_bubble,
  output logic        IF_ID_flush,
  output logic        stall_active,
  output logic [15:0] stall_count
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic        state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic rs_ex, rt_ex, rs_mem;
  logic load_use, br_two, br_one, flag_haz;
  logic stall_run, stall;

  // Producer match terms; register 0 never produces a hazard.
  always_comb begin
    rs_ex  = ID_EX_Regwrite && (ID_EX_RegisterRd != 4'd0) &&
             (ID_EX_RegisterRd == IF_ID_RegisterRs);
    rt_ex  = ID_EX_Regwrite && (ID_EX_RegisterRd != 4'd0) &&
             (ID_EX_RegisterRd == IF_ID_RegisterRt);
    rs_mem = EX_MEM_MemRead && (EX_MEM_RegisterRd != 4'd0) &&
             (EX_MEM_RegisterRd == IF_ID_RegisterRs);
  end

  // Hazard classification; store data from a load is left to MEM-MEM forwarding.
  always_comb begin
    load_use  = ID_EX_MemRead &&
                ((IF_ID_ReadRs && rs_ex) ||
                 (IF_ID_ReadRt && rt_ex && !IF_ID_MemWrite));
    br_two    = IF_ID_BranchReg && rs_ex && ID_EX_MemRead;
    br_one    = IF_ID_BranchReg && (rs_ex ? !ID_EX_MemRead : rs_mem);
    flag_haz  = IF_ID_Branch && ID_EX_SetsFlags;
    stall_run = load_use || br_one || br_two || flag_haz;
  end

  // Next-state logic: only a two-cycle hazard enters HOLD, HOLD always exits.
  always_comb begin
    state_d = ST_RUN;
    if (state_q == ST_RUN && br_two) begin
      state_d = ST_HOLD;
    end
  end

  // Output decode; reset forces the free-running values, stall beats flush.
  always_comb begin
    stall        = 1'b0;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    IF_ID_flush  = 1'b0;
    if (rst_n) begin
      stall = (state_q == ST_HOLD) || stall_run;
      if (stall) begin
        PC_write     = 1'b0;
        IF_ID_write  = 1'b0;
        ID_EX_bubble = 1'b1;
      end else begin
        IF_ID_flush  = BranchTaken;
      end
    end
    stall_active = ID_EX_bubble;
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_active && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit.
module tb_hazard_stall_unit;

  logic        clk;
  logic        rst_n;
  logic        ID_EX_MemRead;
  logic        ID_EX_Regwrite;
  logic [3:0]  ID_EX_RegisterRd;
  logic        ID_EX_SetsFlags;
  logic        EX_MEM_MemRead;
  logic [3:0]  EX_MEM_RegisterRd;
  logic [3:0]  IF_ID_RegisterRs;
  logic [3:0]  IF_ID_RegisterRt;
  logic        IF_ID_ReadRs;
  logic        IF_ID_ReadRt;
  logic        IF_ID_MemWrite;
  logic        IF_ID_BranchReg;
  logic        IF_ID_Branch;
  logic        BranchTaken;
  logic        PC_write;
  logic        IF_ID_write;
  logic        ID_EX_bubble;
  logic        IF_ID_flush;
  logic        stall_active;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  hazard_stall_unit dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_Regwrite    (ID_EX_Regwrite),
    .ID_EX_RegisterRd  (ID_EX_RegisterRd),
    .ID_EX_SetsFlags   (ID_EX_SetsFlags),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_RegisterRd (EX_MEM_RegisterRd),
    .IF_ID_RegisterRs  (IF_ID_RegisterRs),
    .IF_ID_RegisterRt  (IF_ID_RegisterRt),
    .IF_ID_ReadRs      (IF_ID_ReadRs),
    .IF_ID_ReadRt      (IF_ID_ReadRt),
    .IF_ID_MemWrite    (IF_ID_MemWrite),
    .IF_ID_BranchReg   (IF_ID_BranchReg),
    .IF_ID_Branch      (IF_ID_Branch),
    .BranchTaken       (BranchTaken),
    .PC_write          (PC_write),
    .IF_ID_write       (IF_ID_write),
    .ID_EX_bubble      (ID_EX_bubble),
    .IF_ID_flush       (IF_ID_flush),
    .stall_active      (stall_active),
    .stall_count       (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ID_EX_MemRead     = 1'b0;
    ID_EX_Regwrite    = 1'b0;
    ID_EX_RegisterRd  = 4'd0;
    ID_EX_SetsFlags   = 1'b0;
    EX_MEM_MemRead    = 1'b0;
    EX_MEM_RegisterRd = 4'd0;
    IF_ID_RegisterRs  = 4'd0;
    IF_ID_RegisterRt  = 4'd0;
    IF_ID_ReadRs      = 1'b0;
    IF_ID_ReadRt      = 1'b0;
    IF_ID_MemWrite    = 1'b0;
    IF_ID_BranchReg   = 1'b0;
    IF_ID_Branch      = 1'b0;
    BranchTaken       = 1'b0;
  endtask

  // One clock, returning 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    ID_EX_MemRead = 1'b1; ID_EX_Regwrite = 1'b1; ID_EX_RegisterRd = 4'd3;
    IF_ID_RegisterRs = 4'd3; IF_ID_ReadRs = 1'b1; BranchTaken = 1'b1;
    tick(); tick();
    #1;
    checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write: got %b want 1", PC_write); end
    checks++; if (IF_ID_write !== 1'b1) begin errors++; $display("FAIL reset_ifid_write: got %b want 1", IF_ID_write); end
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %b want 0", ID_EX_bubble); end
    checks++; if (IF_ID_flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", IF_ID_flush); end
    checks++; if (stall_active !== 1'b0) begin errors++; $display("FAIL reset_stall_active: got %b want 0", stall_active); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", stall_count); end
    clear_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use();
    ID_EX_MemRead = 1'b1; ID_EX_Regwrite = 1'b1; ID_EX_RegisterRd = 4'd3;
    IF_ID_RegisterRs = 4'd3; IF_ID_ReadRs = 1'b1;
    #1;
    checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL lu_pc_write: got %b want 0", PC_write); end
    checks++; if (IF_ID_write !== 1'b0) begin errors++; $display("FAIL lu_ifid_write: got %b want 0", IF_ID_write); end
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL lu_bubble: got %b want 1", ID_EX_bubble); end
    checks++; if (stall_active !== 1'b1) begin errors++; $display("FAIL lu_stall_active: got %b want 1", stall_active); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL lu_count_before: got %0d want 0", stall_count); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_after: got %0d want 1", stall_count); end
    checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL lu_one_cycle: got PC_write=%b want 1", PC_write); end
    // Rd = 0 never hazards.
    ID_EX_MemRead = 1'b1; ID_EX_Regwrite = 1'b1; ID_EX_RegisterRd = 4'd0;
    IF_ID_RegisterRs = 4'd0; IF_ID_ReadRs = 1'b1;
    #1;
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL lu_rd0: got bubble=%b want 0", ID_EX_bubble); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_rd0_count: got %0d want 1", stall_count); end
  endtask

  task automatic test_store_exempt();
    ID_EX_MemRead = 1'b1; ID_EX_Regwrite = 1'b1; ID_EX_RegisterRd = 4'd5;
    IF_ID_MemWrite = 1'b1; IF_ID_RegisterRt = 4'd5; IF_ID_ReadRt = 1'b1; IF_ID_ReadRs = 1'b0;
    #1;
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL store_exempt: got bubble=%b want 0", ID_EX_bubble); end
    // Same load feeding Rt of a non-store does stall.
    IF_ID_MemWrite = 1'b0;
    #1;
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL load_rt_use: got bubble=%b want 1", ID_EX_bubble); end
    IF_ID_MemWrite = 1'b1;
    IF_ID_RegisterRs = 4'd5; IF_ID_ReadRs = 1'b1;
    #1;
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL store_rs_use: got bubble=%b want 1", ID_EX_bubble); end
    tick();
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL store_count: got %0d want 2", stall_count); end
  endtask

  task automatic test_branch_reg();
    ID_EX_MemRead = 1'b1; ID_EX_Regwrite = 1'b1; ID_EX_RegisterRd = 4'd4;
    IF_ID_BranchReg = 1'b1; IF_ID_RegisterRs = 4'd4; BranchTaken = 1'b1;
    #1;
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL br2_cycle0_bubble: got %b want 1", ID_EX_bubble); end
    checks++; if (IF_ID_flush !== 1'b0) begin errors++; $display("FAIL br2_cycle0_flush: got %b want 0", IF_ID_flush); end
    tick();
    clear_inputs();
    BranchTaken = 1'b1;
    #1;
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL br2_cycle1_bubble: got %b want 1", ID_EX_bubble); end
    checks++; if (PC_write !== 1'b0) begin errors++; $display("FAIL br2_cycle1_pc: got %b want 0", PC_write); end
    checks++; if (IF_ID_flush !== 1'b0) begin errors++; $display("FAIL br2_cycle1_flush: got %b want 0", IF_ID_flush); end
    tick();
    BranchTaken = 1'b0;
    #1;
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL br2_cycle2_run: got bubble=%b want 0", ID_EX_bubble); end
    checks++; if (stall_count !== 16'd4) begin errors++; $display("FAIL br2_count: got %0d want 4", stall_count); end
    // ALU producer in EX feeding a register branch: one stall.
    ID_EX_Regwrite = 1'b1; ID_EX_RegisterRd = 4'd6;
    IF_ID_BranchReg = 1'b1; IF_ID_RegisterRs = 4'd6;
    #1;
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL br1_alu_bubble: got %b want 1", ID_EX_bubble); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL br1_alu_release: got bubble=%b want 0", ID_EX_bubble); end
    // Load in MEM feeding a register branch: one stall.
    EX_MEM_MemRead = 1'b1; EX_MEM_RegisterRd = 4'd7;
    IF_ID_BranchReg = 1'b1; IF_ID_RegisterRs = 4'd7;
    #1;
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL br1_mem_bubble: got %b want 1", ID_EX_bubble); end
    tick();
    clear_inputs();
    #1;
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL br1_mem_release: got bubble=%b want 0", ID_EX_bubble); end
    checks++; if (stall_count !== 16'd6) begin errors++; $display("FAIL br1_count: got %0d want 6", stall_count); end
    EX_MEM_MemRead = 1'b1; EX_MEM_RegisterRd = 4'd0;
    IF_ID_BranchReg = 1'b1; IF_ID_RegisterRs = 4'd0;
    #1;
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL br_mem_rd0: got bubble=%b want 0", ID_EX_bubble); end
    clear_inputs();
  endtask

  task automatic test_flag_flush();
    ID_EX_SetsFlags = 1'b1; IF_ID_Branch = 1'b1; BranchTaken = 1'b1;
    #1;
    checks++; if (ID_EX_bubble !== 1'b1) begin errors++; $display("FAIL flag_bubble: got %b want 1", ID_EX_bubble); end
    checks++; if (IF_ID_flush !== 1'b0) begin errors++; $display("FAIL flag_flush: got %b want 0", IF_ID_flush); end
    tick();
    ID_EX_SetsFlags = 1'b0;
    #1;
    checks++; if (IF_ID_flush !== 1'b1) begin errors++; $display("FAIL taken_flush: got %b want 1", IF_ID_flush); end
    checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL taken_pc_write: got %b want 1", PC_write); end
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL taken_bubble: got %b want 0", ID_EX_bubble); end
    checks++; if (stall_count !== 16'd7) begin errors++; $display("FAIL flag_count: got %0d want 7", stall_count); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_in_hold();
    ID_EX_MemRead = 1'b1; ID_EX_Regwrite = 1'b1; ID_EX_RegisterRd = 4'd9;
    IF_ID_BranchReg = 1'b1; IF_ID_RegisterRs = 4'd9;
    tick();
    clear_inputs();
    BranchTaken = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (PC_write !== 1'b1) begin errors++; $display("FAIL hold_rst_pc: got %b want 1", PC_write); end
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL hold_rst_bubble: got %b want 0", ID_EX_bubble); end
    checks++; if (IF_ID_flush !== 1'b0) begin errors++; $display("FAIL hold_rst_flush: got %b want 0", IF_ID_flush); end
    checks++; if (stall_active !== 1'b0) begin errors++; $display("FAIL hold_rst_active: got %b want 0", stall_active); end
    tick();
    rst_n = 1'b1;
    BranchTaken = 1'b0;
    #1;
    checks++; if (ID_EX_bubble !== 1'b0) begin errors++; $display("FAIL hold_rst_run: got bubble=%b want 0", ID_EX_bubble); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL hold_rst_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_saturation();
    ID_EX_SetsFlags = 1'b1; IF_ID_Branch = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_near: got %h want fffe", stall_count); end
    tick();
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want ffff", stall_count); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", stall_count); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_store_exempt();
    test_branch_reg();
    test_flag_flush();
    test_reset_in_hold();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
